// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALU-control decode, single-cycle ops and an iterative
// shift-add multiplier that stalls the pipeline via ready_o while it runs.
module alu_exec_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MUL_STEP_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned Steps = XLEN / MUL_STEP_BITS;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam int unsigned ShW   = $clog2(XLEN);

  typedef enum logic [0:0] {StIdle, StMul} state_e;
  typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpXor, OpSll, OpSra, OpMul} alu_op_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  alu_op_e           op;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   pp;
  logic [ShW-1:0]    shamt;

  assign shamt = src2_i[ShW-1:0];

  // ALU-control decode, first match wins; everything unmatched falls to SRAI
  always_comb begin
    op = OpSra;
    if (ALUOp_i == 2'b11 && funct7_i == 7'b0000000 && funct3_i == 3'b111) begin
      op = OpAnd;
    end else if (ALUOp_i == 2'b11 && funct7_i == 7'b0000000 && funct3_i == 3'b100) begin
      op = OpXor;
    end else if (ALUOp_i == 2'b11 && funct7_i == 7'b0000000 && funct3_i == 3'b001) begin
      op = OpSll;
    end else if (ALUOp_i == 2'b11 && funct7_i == 7'b0000000 && funct3_i == 3'b000) begin
      op = OpAdd;
    end else if (ALUOp_i == 2'b11 && funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
      op = OpSub;
    end else if (ALUOp_i == 2'b11 && funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
      op = OpMul;
    end else if (ALUOp_i == 2'b01 && funct3_i == 3'b000) begin
      op = OpAdd;
    end else if (ALUOp_i == 2'b00 && funct3_i == 3'b010) begin
      op = OpAdd;
    end else if (ALUOp_i == 2'b10 && funct3_i == 3'b010) begin
      op = OpAdd;
    end
  end

  // Single-cycle datapath
  always_comb begin
    alu_res = '0;
    unique case (op)
      OpAdd:   alu_res = src1_i + src2_i;
      OpSub:   alu_res = src1_i - src2_i;
      OpAnd:   alu_res = src1_i & src2_i;
      OpXor:   alu_res = src1_i ^ src2_i;
      OpSll:   alu_res = src1_i << shamt;
      OpSra:   alu_res = XLEN'($signed(src1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Partial product of the low MUL_STEP_BITS multiplier bits, modulo 2^XLEN
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(MUL_STEP_BITS); i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  // Next-state: accept/issue in idle, shift-add iteration in mul; flush wins
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (op == OpMul) begin
              mcand_d  = src1_i;
              mplier_d = src2_i;
              acc_d    = '0;
              cnt_d    = CntW'(Steps);
              state_d  = StMul;
            end else begin
              result_d = alu_res;
              valid_d  = 1'b1;
            end
          end
        end
        StMul: begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << MUL_STEP_BITS;
          mplier_d = mplier_q >> MUL_STEP_BITS;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            result_d = acc_q + pp;
            valid_d  = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q == StMul);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: two instances (1 and 4 multiplier bits per cycle)
// share stimulus; an op-level model is compared every cycle, plus literals.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [6:0]  funct7_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [1:0]  ALUOp_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;

  logic        ready_a, valid_a, busy_a;
  logic [31:0] result_a;
  logic        ready_b, valid_b, busy_b;
  logic [31:0] result_b;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit #(.XLEN(32), .MUL_STEP_BITS(1)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .ALUOp_i(ALUOp_i),
    .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_a), .valid_o(valid_a),
    .result_o(result_a), .busy_o(busy_a)
  );

  alu_exec_unit #(.XLEN(32), .MUL_STEP_BITS(4)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .ALUOp_i(ALUOp_i),
    .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_b), .valid_o(valid_b),
    .result_o(result_b), .busy_o(busy_b)
  );

  // Op-level model: {is_mul, value}; MUL is a plain 64-bit product
  function automatic logic [32:0] model_op(input logic [1:0] al, input logic [6:0] f7,
                                           input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    if (al == 2'b11 && f7 == 7'h00 && f3 == 3'b111) return {1'b0, a & b};
    if (al == 2'b11 && f7 == 7'h00 && f3 == 3'b100) return {1'b0, a ^ b};
    if (al == 2'b11 && f7 == 7'h00 && f3 == 3'b001) return {1'b0, a << b[4:0]};
    if (al == 2'b11 && f7 == 7'h00 && f3 == 3'b000) return {1'b0, a + b};
    if (al == 2'b11 && f7 == 7'h20 && f3 == 3'b000) return {1'b0, a - b};
    if (al == 2'b11 && f7 == 7'h01 && f3 == 3'b000) begin
      p = {32'h0, a} * {32'h0, b};
      return {1'b1, p[31:0]};
    end
    if ((al == 2'b01 && f3 == 3'b000) || (al == 2'b00 && f3 == 3'b010) ||
        (al == 2'b10 && f3 == 3'b010)) return {1'b0, a + b};
    return {1'b0, 32'($signed(a) >>> b[4:0])};
  endfunction

  wire [32:0] m_op = model_op(ALUOp_i, funct7_i, funct3_i, src1_i, src2_i);

  int          m_busy[2]   = '{0, 0};
  logic        m_valid[2]  = '{1'b0, 1'b0};
  logic [31:0] m_result[2] = '{32'h0, 32'h0};
  logic [31:0] m_prod[2]   = '{32'h0, 32'h0};

  // Model update: busy counts remaining multiply cycles
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 0; m_valid[k] <= 1'b0; m_result[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush_i) begin
          m_busy[k] <= 0;
          m_valid[k] <= 1'b0;
        end else if (m_busy[k] != 0) begin
          m_busy[k] <= m_busy[k] - 1;
          m_valid[k] <= (m_busy[k] == 1);
          if (m_busy[k] == 1) m_result[k] <= m_prod[k];
        end else begin
          m_valid[k] <= 1'b0;
          if (valid_i) begin
            if (m_op[32]) begin
              m_prod[k] <= m_op[31:0];
              m_busy[k] <= (k == 0) ? 32 : 8;
            end else begin
              m_result[k] <= m_op[31:0];
              m_valid[k] <= 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk_i) begin
    check("a.ready", 32'(ready_a), 32'(m_busy[0] == 0));
    check("a.busy", 32'(busy_a), 32'(m_busy[0] != 0));
    check("a.valid", 32'(valid_a), 32'(m_valid[0]));
    check("a.result", result_a, m_result[0]);
    check("b.ready", 32'(ready_b), 32'(m_busy[1] == 0));
    check("b.busy", 32'(busy_b), 32'(m_busy[1] != 0));
    check("b.valid", 32'(valid_b), 32'(m_valid[1]));
    check("b.result", result_b, m_result[1]);
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] al, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = v; ALUOp_i = al; funct7_i = f7; funct3_i = f3; src1_i = a; src2_i = b;
  endtask

  int cnt;
  int seen;

  initial begin
    #1 rst_i = 1'b0;
    #1;
    check("rst.ready", 32'(ready_a), 32'h1);
    check("rst.valid", 32'(valid_a), 32'h0);
    check("rst.busy", 32'(busy_a), 32'h0);
    check("rst.result", result_a, 32'h0);
    step(); step();
    rst_i = 1'b1;
    step();

    // 1: ADD overflow wraps
    drive(1, 2'b11, 7'h00, 3'b000, 32'h7FFFFFFF, 32'h1); step();
    check("t1.valid", 32'(valid_a), 32'h1);
    check("t1.result", result_a, 32'h80000000);
    check("t1.ready", 32'(ready_a), 32'h1);

    // 2: back-to-back SUB, SRAI, AND
    drive(1, 2'b11, 7'h20, 3'b000, 32'd5, 32'd7); step();
    check("t2.sub", result_a, 32'hFFFFFFFE);
    check("t2.sub_v", 32'(valid_a), 32'h1);
    drive(1, 2'b00, 7'h00, 3'b000, 32'h80000010, 32'd4); step();
    check("t2.srai", result_a, 32'hF8000001);
    check("t2.srai_v", 32'(valid_a), 32'h1);
    drive(1, 2'b11, 7'h00, 3'b111, 32'h0000F0F0, 32'h00000FF0); step();
    check("t2.and", result_a, 32'h000000F0);
    check("t2.and_v", 32'(valid_a), 32'h1);
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0); step();
    check("t2.idle_v", 32'(valid_a), 32'h0);

    // 3: MUL 7 x -3, ADD held throughout
    drive(1, 2'b11, 7'h01, 3'b000, 32'd7, 32'hFFFFFFFD); step();
    drive(1, 2'b11, 7'h00, 3'b000, 32'd1, 32'd2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid_a) break;
      if (!ready_a && busy_a) cnt++;
      step();
    end
    check("t3.stall_cycles", 32'(cnt), 32'd32);
    check("t3.mul_valid", 32'(valid_a), 32'h1);
    check("t3.mul", result_a, 32'hFFFFFFEB);
    check("t3.ready_done", 32'(ready_a), 32'h1);
    step();
    check("t3.add_valid", 32'(valid_a), 32'h1);
    check("t3.add", result_a, 32'd3);
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0); step(); step();

    // 4: 4-bit-step multiplier finishes 8 edges after accept
    drive(1, 2'b11, 7'h01, 3'b000, 32'h12345678, 32'h10); step();
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    for (int i = 1; i < 8; i++) step();
    check("t4.early_v", 32'(valid_b), 32'h0);
    step();
    check("t4.valid", 32'(valid_b), 32'h1);
    check("t4.result", result_b, 32'h23456780);
    repeat (30) step();
    check("t4.a_result", result_a, 32'h23456780);

    // 5: flush at the 10th multiply cycle
    drive(1, 2'b11, 7'h01, 3'b000, 32'd3, 32'd5); step();
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    repeat (9) step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("t5.ready", 32'(ready_a), 32'h1);
    check("t5.busy", 32'(busy_a), 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_a) seen++;
      step();
    end
    check("t5.no_valid", 32'(seen), 32'h0);
    check("t5.result_kept", result_a, 32'h23456780);

    // 6: async reset mid-multiply, then LW address
    drive(1, 2'b11, 7'h01, 3'b000, 32'd9, 32'd9); step();
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    repeat (5) step();
    rst_i = 1'b0;
    #1;
    check("t6.ready", 32'(ready_a), 32'h1);
    check("t6.busy", 32'(busy_a), 32'h0);
    check("t6.valid", 32'(valid_a), 32'h0);
    check("t6.result", result_a, 32'h0);
    step(); step();
    rst_i = 1'b1;
    drive(1, 2'b00, 7'h00, 3'b010, 32'h1000, 32'h20); step();
    check("t6.lw_valid", 32'(valid_a), 32'h1);
    check("t6.lw", result_a, 32'h1020);
    drive(0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0); step();
    check("t6.lw_pulse", 32'(valid_a), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
